// File: rtl/seq_feed_ctrl_if.sv
// rtl/seq_feed_ctrl_if.sv - host/detector signal bundle for the sequence feed controller
interface seq_feed_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start;
    logic [WIDTH-1:0] word_in;
    logic             abort;
    logic             det_outp;
    logic             det_inp;
    logic             det_clr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic [WIDTH-1:0] match_mask;

    // Controller side: takes host requests and detector output, drives everything else.
    modport slave (
        input  start, word_in, abort, det_outp,
        output det_inp, det_clr, busy, done, match_cnt, match_mask
    );

    // Host/environment side: issues words and carries the detector's output back.
    modport master (
        output start, word_in, abort, det_outp,
        input  det_inp, det_clr, busy, done, match_cnt, match_mask
    );
endinterface

// File: rtl/seq_feed_ctrl.sv
// rtl/seq_feed_ctrl.sv - clears a Moore detector, feeds it a word LSB first, collects its hits
module seq_feed_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    seq_feed_ctrl_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             det_inp_q;
    logic             det_clr_q;
    logic             busy_q;
    logic             done_q;
    logic             active;

    // Abort is only honoured while a word is actually in flight.
    assign active = (state_q == S_CLR) || (state_q == S_SHIFT) || (state_q == S_DRAIN);

    // Sequencer: every output is set up one edge ahead for the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            det_inp_q <= 1'b0;
            det_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            det_clr_q <= 1'b0;
            if (active && bus.abort) begin
                // Results of a cancelled word are meaningless, so they are dropped and
                // the detector is cleared once more on the way back to idle.
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                det_inp_q <= 1'b0;
                det_clr_q <= 1'b1;
                cnt_q     <= '0;
                mask_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        det_inp_q <= 1'b0;
                        busy_q    <= 1'b0;
                        if (bus.start) begin
                            word_q    <= bus.word_in;
                            cnt_q     <= '0;
                            mask_q    <= '0;
                            busy_q    <= 1'b1;
                            det_clr_q <= 1'b1;
                            state_q   <= S_CLR;
                        end
                    end
                    S_CLR: begin
                        idx_q     <= '0;
                        det_inp_q <= word_q[0];
                        state_q   <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        // det_outp now reflects the previous bit; bit 0 follows a clear.
                        if ((idx_q != '0) && bus.det_outp) begin
                            mask_q[idx_q - IDX_ONE] <= 1'b1;
                            cnt_q                   <= cnt_q + CNT_ONE;
                        end
                        if (idx_q == LAST_IDX) begin
                            det_inp_q <= 1'b0;
                            state_q   <= S_DRAIN;
                        end else begin
                            idx_q     <= idx_q + IDX_ONE;
                            det_inp_q <= word_q[idx_q + IDX_ONE];
                        end
                    end
                    S_DRAIN: begin
                        // One extra cycle to catch the detector's response to the last bit.
                        if (bus.det_outp) begin
                            mask_q[WIDTH-1] <= 1'b1;
                            cnt_q           <= cnt_q + CNT_ONE;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The detector is held clear for as long as reset is asserted, not just after the edge.
    assign bus.det_clr    = det_clr_q | ~rst;
    assign bus.det_inp    = det_inp_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.match_cnt  = cnt_q;
    assign bus.match_mask = mask_q;
endmodule
